// File: rtl/retire_trace_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : retire_trace_buffer_pkg
// Description : Shared types and constants for the retire trace buffer:
//               retire record layout, default depth, slot popcount helper.
// Revision    : 1.0 - initial release
// ============================================================================
package retire_trace_buffer_pkg;

  localparam int XLEN             = 32;
  localparam int RetireTraceDepth = 16;

  // One retired instruction as seen by the trace consumer (166 bits at XLEN=32)
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] reg_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            mem_wrt;
  } retire_rec_t;

  localparam int RecW = $bits(retire_rec_t);

  // Slot counts never exceed 4, so three bits always suffice
  localparam int SlotCntW = 3;

  function automatic logic [SlotCntW-1:0] slot_popcount(input logic [3:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 4; i++) begin
      c += int'(v[i]);
    end
    return SlotCntW'(c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/retire_trace_buffer_compactor.sv
`default_nettype none
// ============================================================================
// Module      : retire_compactor
// Description : Packs the valid retire slots into a dense, program-ordered
//               write vector and splits them into written and dropped counts
//               according to the FIFO space available this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module retire_compactor
  import retire_trace_buffer_pkg::*;
#(
  parameter int IssueWidth = 2,
  parameter int Depth      = RetireTraceDepth,
  localparam int PtrW      = $clog2(Depth) + 1
) (
  input  logic [IssueWidth-1:0]      update_i,
  input  logic [IssueWidth*RecW-1:0] slot_rec_i,
  input  logic [PtrW-1:0]            free_i,
  output logic [IssueWidth*RecW-1:0] wr_rec_o,
  output logic [SlotCntW-1:0]        n_valid_o,
  output logic [SlotCntW-1:0]        n_write_o,
  output logic [SlotCntW-1:0]        n_drop_o
);

  assign n_valid_o = slot_popcount(4'(update_i));

  // Lowest valid slots claim free entries first; anything beyond free is dropped
  always_comb begin
    int wr_cnt;
    int drop_cnt;
    wr_rec_o = '0;
    wr_cnt   = 0;
    drop_cnt = 0;
    for (int s = 0; s < IssueWidth; s++) begin
      if (update_i[s]) begin
        if (wr_cnt < int'(free_i)) begin
          wr_rec_o[wr_cnt*RecW +: RecW] = slot_rec_i[s*RecW +: RecW];
          wr_cnt = wr_cnt + 1;
        end else begin
          drop_cnt = drop_cnt + 1;
        end
      end
    end
    n_write_o = SlotCntW'(wr_cnt);
    n_drop_o  = SlotCntW'(drop_cnt);
  end

endmodule
`default_nettype wire

// File: rtl/retire_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : retire_trace_buffer
// Description : Captures up to IssueWidth retire records per cycle into a
//               circular FIFO and streams them out one per cycle over a
//               show-ahead valid/ready interface. Counts retirements and
//               overflow drops, with a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module retire_trace_buffer
  import retire_trace_buffer_pkg::*;
#(
  parameter int IssueWidth = 2,
  parameter int Depth      = RetireTraceDepth,
  localparam int PtrW      = $clog2(Depth) + 1
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [IssueWidth-1:0]      update_i,
  input  logic [IssueWidth*XLEN-1:0] pc_i,
  input  logic [IssueWidth*XLEN-1:0] instr_i,
  input  logic [IssueWidth*5-1:0]    reg_addr_i,
  input  logic [IssueWidth*XLEN-1:0] reg_data_i,
  input  logic [IssueWidth*XLEN-1:0] mem_addr_i,
  input  logic [IssueWidth*XLEN-1:0] mem_data_i,
  input  logic [IssueWidth-1:0]      mem_wrt_i,
  output logic                       rec_valid_o,
  input  logic                       rec_ready_i,
  output logic [RecW-1:0]            rec_o,
  output logic [PtrW-1:0]            level_o,
  output logic [31:0]                retired_count_o,
  output logic [31:0]                drop_count_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(Depth);

  // FIFO storage is deliberately not reset: the pointers alone define occupancy
  retire_rec_t mem_q [Depth];

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [31:0]     retired_q, retired_d;
  logic [31:0]     drop_q, drop_d;
  logic            overflow_q, overflow_d;

  logic [IssueWidth*RecW-1:0] slot_recs;
  logic [IssueWidth*RecW-1:0] wr_recs;
  logic [SlotCntW-1:0]        n_valid;
  logic [SlotCntW-1:0]        n_write;
  logic [SlotCntW-1:0]        n_drop;
  logic [PtrW-1:0]            free_space;
  logic                       pop;
  logic [AW-1:0]              wr_addr [IssueWidth];

  // Assemble each slot's fields into the packed record layout
  for (genvar s = 0; s < IssueWidth; s++) begin : g_slot
    assign slot_recs[s*RecW +: RecW] = {pc_i[s*XLEN +: XLEN],
                                        instr_i[s*XLEN +: XLEN],
                                        reg_addr_i[s*5 +: 5],
                                        reg_data_i[s*XLEN +: XLEN],
                                        mem_addr_i[s*XLEN +: XLEN],
                                        mem_data_i[s*XLEN +: XLEN],
                                        mem_wrt_i[s]};
  end

  // Occupancy and stream outputs come straight from the pointer pair
  assign level_o     = wptr_q - rptr_q;
  assign rec_valid_o = (wptr_q != rptr_q);
  assign rec_o       = rec_valid_o ? mem_q[rptr_q[AW-1:0]] : '0;
  assign pop         = rec_valid_o & rec_ready_i;

  // A pop in the same cycle frees its entry for this cycle's pushes
  assign free_space = PtrW'(Depth) - level_o + PtrW'(pop);

  retire_compactor #(
    .IssueWidth (IssueWidth),
    .Depth      (Depth)
  ) u_compactor (
    .update_i   (update_i),
    .slot_rec_i (slot_recs),
    .free_i     (free_space),
    .wr_rec_o   (wr_recs),
    .n_valid_o  (n_valid),
    .n_write_o  (n_write),
    .n_drop_o   (n_drop)
  );

  // Consecutive FIFO addresses for the compacted write lanes
  always_comb begin
    for (int k = 0; k < IssueWidth; k++) begin
      wr_addr[k] = wptr_q[AW-1:0] + AW'(k);
    end
  end

  // Next-state for pointers and statistics
  always_comb begin
    wptr_d     = wptr_q + PtrW'(n_write);
    rptr_d     = rptr_q + PtrW'(pop);
    retired_d  = retired_q + 32'(n_valid);
    drop_d     = drop_q + 32'(n_drop);
    overflow_d = overflow_q | (n_drop != '0);
  end

  // Pointer and counter state; reset discards every buffered record at once
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      retired_q  <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      retired_q  <= retired_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  // Write the accepted records into consecutive entries starting at wptr
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < IssueWidth; k++) begin
      if (k < int'(n_write)) begin
        mem_q[wr_addr[k]] <= wr_recs[k*RecW +: RecW];
      end
    end
  end

  assign retired_count_o = retired_q;
  assign drop_count_o    = drop_q;
  assign overflow_o      = overflow_q;

endmodule
`default_nettype wire
